uart_tx_buffered: RTL

Buffered UART transmitter: the transmit counterpart to uart_rx_deserialise, with a byte FIFO in front of the serialiser. Accepts bytes on a valid/ready interface, queues up to FIFO_DEPTH bytes, and sends each as an 8N1 frame on tx_bits. Frames go back-to-back with no idle gap. Lets a producer emit multi-byte messages without tracking per-byte serialiser readiness.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_byte_fifo.sv | 50 +++++
 rtl/uart_tx_buffered.sv | 106 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Used by the buffered transmitter and its serial siblings.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    function automatic int clks_per_bit(input int clk_rate, input int baud_rate);
        return clk_rate / baud_rate;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Single-clock byte FIFO with wrap-bit pointers.
// Read data is presented combinationally at the read pointer.
module uart_byte_fifo
#(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [7:0]              din,
    output logic [7:0]              dout,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // Extra pointer bit distinguishes full from empty.
    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ONE;
            if (do_pop)  rd_ptr <= rd_ptr + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a
// registered-output serialiser with back-to-back frames.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_RATE   = 12000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   tx_byte,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    output logic                         tx_bits,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int CPB = clks_per_bit(CLK_RATE, BAUD_RATE);
    localparam int CW  = $clog2(CPB);
    localparam logic [CW-1:0] LAST_CLK = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [2:0]    idx_next;
    logic [7:0]    shift;
    logic          line_next;
    logic          bit_done;
    logic          pop;
    logic          full;
    logic          empty;
    logic [7:0]    fifo_dout;

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_valid & ~full),
        .pop   (pop),
        .din   (tx_byte),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    assign tx_ready = ~full;
    assign busy     = (state != IDLE) | (fifo_count != '0);
    assign bit_done = (cnt == LAST_CLK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (!empty) state_next = START;
            START:   if (bit_done) state_next = DATA;
            DATA:    if (bit_done && idx == LAST_BIT) state_next = STOP;
            STOP:    if (bit_done) state_next = empty ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    // Line level is computed for the next state so tx_bits can be a flop.
    always_comb begin
        pop       = 1'b0;
        idx_next  = idx;
        line_next = 1'b1;
        unique case (state)
            IDLE:    pop = !empty;
            START:   idx_next = '0;
            DATA:    if (bit_done) idx_next = idx + 3'd1;
            STOP:    pop = bit_done && !empty;
            default: ;
        endcase
        unique case (state_next)
            START:   line_next = 1'b0;
            DATA:    line_next = shift[idx_next];
            default: line_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            idx     <= '0;
            shift   <= '0;
            tx_bits <= 1'b1;
        end else begin
            cnt     <= (state == IDLE || bit_done) ? '0 : cnt + CNT_ONE;
            idx     <= idx_next;
            tx_bits <= line_next;
            if (pop) shift <= fifo_dout;
        end
    end

endmodule
